// File: rtl/adder_err_pkg.sv
// adder_err_pkg: FSM states and width derivations shared by adder_error_monitor and its error stage
package adder_err_pkg;
    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;
    function automatic int err_w(input int width);
        return width + 2;
    endfunction
    function automatic int abs_w(input int width);
        return width + 1;
    endfunction
    function automatic int sq_w(input int width);
        return 2 * width + 2;
    endfunction
    function automatic int acc_w(input int width, input int samples_log2);
        return 2 * width + 2 + samples_log2;
    endfunction
endpackage

// File: rtl/adder_error_monitor_if.sv
// adder_error_monitor_if: sample input stream and window report stream of the adder error monitor
interface adder_error_monitor_if
    import adder_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAMPLES_LOG2 = 8
);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0] approx_sum;
    logic out_valid;
    logic out_ready;
    logic [SAMPLES_LOG2:0] err_count;
    logic [acc_w(WIDTH, SAMPLES_LOG2)-1:0] sq_err_sum;
    logic [WIDTH:0] max_abs_err;
    modport master (
        output in_valid, in_a, in_b, approx_sum, out_ready,
        input in_ready, out_valid, err_count, sq_err_sum, max_abs_err
    );
    modport slave (
        input in_valid, in_a, in_b, approx_sum, out_ready,
        output in_ready, out_valid, err_count, sq_err_sum, max_abs_err
    );
endinterface

// File: rtl/err_calc_stage.sv
// err_calc_stage: combinational exact sum, signed error, square and magnitude of one adder sample
// abs_err port exists only when ADDER_ERR_MAX_TRACK_EN is defined
module err_calc_stage
    import adder_err_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH:0] approx,
    output logic signed [err_w(WIDTH)-1:0] err,
    output logic [sq_w(WIDTH)-1:0] sq
`ifdef ADDER_ERR_MAX_TRACK_EN
    , output logic [abs_w(WIDTH)-1:0] abs_err
`endif
);
    localparam int EW = err_w(WIDTH);
    localparam int AW = abs_w(WIDTH);
    localparam int SW = sq_w(WIDTH);
    logic [WIDTH:0] exact;
    logic [AW-1:0] mag;
    assign exact = {1'b0, a} + {1'b0, b};
    assign err = $signed({1'b0, approx}) - $signed({1'b0, exact});
    // |err| < 2^(WIDTH+1), so the magnitude always fits AW bits
    assign mag = AW'(err[EW-1] ? -err : err);
    assign sq = SW'(mag) * SW'(mag);
`ifdef ADDER_ERR_MAX_TRACK_EN
    assign abs_err = mag;
`endif
endmodule

// File: rtl/adder_error_monitor.sv
// adder_error_monitor: accumulates error count, squared error and max |error| of an approximate adder per window
// Define ADDER_ERR_MAX_TRACK_EN to track max_abs_err; otherwise it reads constant 0
module adder_error_monitor
    import adder_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAMPLES_LOG2 = 8
) (
    input logic clk,
    input logic rst,
    adder_error_monitor_if.slave bus
);
    localparam int EW = err_w(WIDTH);
    localparam int SW = sq_w(WIDTH);
    localparam int QW = acc_w(WIDTH, SAMPLES_LOG2);
    localparam int CW = SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0] WINDOW = CW'(1) << SAMPLES_LOG2;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic accept;
    logic clear;
    logic s1_valid;
    logic signed [EW-1:0] calc_err, s1_err;
    logic [SW-1:0] calc_sq, s1_sq;
    logic [CW-1:0] err_cnt;
    logic [QW-1:0] sq_acc;
`ifdef ADDER_ERR_MAX_TRACK_EN
    logic [WIDTH:0] calc_abs, s1_abs, max_acc;
`endif
    err_calc_stage #(.WIDTH(WIDTH)) u_calc (
        .a(bus.in_a),
        .b(bus.in_b),
        .approx(bus.approx_sum),
        .err(calc_err),
        .sq(calc_sq)
`ifdef ADDER_ERR_MAX_TRACK_EN
        , .abs_err(calc_abs)
`endif
    );
    assign bus.in_ready = state == ACCUM && cnt < WINDOW;
    assign bus.out_valid = state == REPORT;
    assign accept = bus.in_valid && bus.in_ready;
    assign clear = state == REPORT && bus.out_ready;
    always_ff @(posedge clk) begin
        state <= rst ? ACCUM : state_n;
    end
    // DRAIN waits until the last sample has left stage 1 and landed in the accumulators
    always_comb begin
        state_n = state;
        state_n = state == ACCUM ? (accept && cnt == WINDOW - 1'b1 ? DRAIN : ACCUM)
                : state == DRAIN ? (s1_valid ? DRAIN : REPORT)
                : (bus.out_ready ? ACCUM : REPORT);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            s1_valid <= 1'b0;
            s1_err <= '0;
            s1_sq <= '0;
            err_cnt <= '0;
            sq_acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            err_cnt <= '0;
            sq_acc <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                cnt <= cnt + 1'b1;
                s1_err <= calc_err;
                s1_sq <= calc_sq;
            end
            if (s1_valid) begin
                err_cnt <= err_cnt + CW'(s1_err != '0);
                sq_acc <= sq_acc + QW'(s1_sq);
            end
        end
    end
    assign bus.err_count = bus.out_valid ? err_cnt : '0;
    assign bus.sq_err_sum = bus.out_valid ? sq_acc : '0;
`ifdef ADDER_ERR_MAX_TRACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_abs <= '0;
            max_acc <= '0;
        end else if (clear) begin
            max_acc <= '0;
        end else begin
            if (accept) s1_abs <= calc_abs;
            if (s1_valid && s1_abs > max_acc) max_acc <= s1_abs;
        end
    end
    assign bus.max_abs_err = bus.out_valid ? max_acc : '0;
`else
    assign bus.max_abs_err = '0;
`endif
endmodule
